// File: rtl/infobus_pkg.sv
// Shared definitions for the XVGA timing/user information bus: timing constants,
// bus layout, sample record and the coordinate clamp helpers.
package infobus_pkg;

    localparam int H_ACTIVE    = 1024;
    localparam int H_FP        = 24;
    localparam int H_SYNC      = 136;
    localparam int H_BP        = 160;
    localparam int H_TOTAL     = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int HSYNC_START = H_ACTIVE + H_FP;
    localparam int HSYNC_END   = HSYNC_START + H_SYNC - 1;

    localparam int V_ACTIVE    = 768;
    localparam int V_FP        = 3;
    localparam int V_SYNC      = 6;
    localparam int V_BP        = 29;
    localparam int V_TOTAL     = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int VSYNC_START = V_ACTIVE + V_FP;
    localparam int VSYNC_END   = VSYNC_START + V_SYNC - 1;

    localparam int HC_W  = 11;
    localparam int VC_W  = 10;
    localparam int X_W   = 11;
    localparam int Y_W   = 10;
    localparam int BUS_W = 69;

    localparam int ZERO_BIT  = 68;
    localparam int HC_MSB    = 67;
    localparam int HC_LSB    = 57;
    localparam int VC_MSB    = 56;
    localparam int VC_LSB    = 47;
    localparam int HSYNC_BIT = 46;
    localparam int VSYNC_BIT = 45;
    localparam int BLANK_BIT = 44;
    localparam int H1X_MSB   = 43;
    localparam int H1X_LSB   = 33;
    localparam int H1Y_MSB   = 32;
    localparam int H1Y_LSB   = 23;
    localparam int H2X_MSB   = 22;
    localparam int H2X_LSB   = 12;
    localparam int H2Y_MSB   = 11;
    localparam int H2Y_LSB   = 2;
    localparam int GRAB2_BIT = 1;
    localparam int GRAB1_BIT = 0;

    typedef enum logic {
        GRAB_STABLE   = 1'b0,
        GRAB_CHANGING = 1'b1
    } grab_state_t;

    typedef struct packed {
        logic [X_W-1:0] x1;
        logic [Y_W-1:0] y1;
        logic [X_W-1:0] x2;
        logic [Y_W-1:0] y2;
        logic           g2;
        logic           g1;
    } hand_sample_t;

    function automatic logic [X_W-1:0] clamp_x(input logic [X_W-1:0] x);
        return (x > X_W'(H_ACTIVE - 1)) ? X_W'(H_ACTIVE - 1) : x;
    endfunction

    function automatic logic [Y_W-1:0] clamp_y(input logic [Y_W-1:0] y);
        return (y > Y_W'(V_ACTIVE - 1)) ? Y_W'(V_ACTIVE - 1) : y;
    endfunction

endpackage

// File: rtl/xvga_timing.sv
// 1024x768 XVGA raster generator: registered counters with sync/blank/frame_start
// aligned to the same pixel, plus the vblank-entry commit strobe.
module xvga_timing
    import infobus_pkg::*;
(
    input  logic            clockin,
    input  logic            reset_n,
    output logic [HC_W-1:0] hcount,
    output logic [VC_W-1:0] vcount,
    output logic            hsync,
    output logic            vsync,
    output logic            blank,
    output logic            frame_start,
    output logic            commit
);

    logic [HC_W-1:0] hcount_r;
    logic [VC_W-1:0] vcount_r;
    logic [HC_W-1:0] hcount_nxt_s;
    logic [VC_W-1:0] vcount_nxt_s;
    logic            hsync_r;
    logic            vsync_r;
    logic            blank_r;
    logic            frame_start_r;
    logic            run_r;

    // Next raster position; the first edge after reset re-presents 0/0 so it carries frame_start
    always_comb begin
        hcount_nxt_s = hcount_r;
        vcount_nxt_s = vcount_r;
        if (!run_r) begin
            hcount_nxt_s = '0;
            vcount_nxt_s = '0;
        end else if (hcount_r == HC_W'(H_TOTAL - 1)) begin
            hcount_nxt_s = '0;
            if (vcount_r == VC_W'(V_TOTAL - 1)) begin
                vcount_nxt_s = '0;
            end else begin
                vcount_nxt_s = vcount_r + 10'd1;
            end
        end else begin
            hcount_nxt_s = hcount_r + 11'd1;
        end
    end

    assign commit = run_r && (hcount_nxt_s == '0) && (vcount_nxt_s == VC_W'(V_ACTIVE));

    // Raster registers, all derived from the same next position to stay aligned
    always_ff @(posedge clockin or negedge reset_n) begin
        if (!reset_n) begin
            run_r         <= 1'b0;
            hcount_r      <= '0;
            vcount_r      <= '0;
            hsync_r       <= 1'b1;
            vsync_r       <= 1'b1;
            blank_r       <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            run_r         <= 1'b1;
            hcount_r      <= hcount_nxt_s;
            vcount_r      <= vcount_nxt_s;
            hsync_r       <= !((hcount_nxt_s >= HC_W'(HSYNC_START)) &&
                               (hcount_nxt_s <= HC_W'(HSYNC_END)));
            vsync_r       <= !((vcount_nxt_s >= VC_W'(VSYNC_START)) &&
                               (vcount_nxt_s <= VC_W'(VSYNC_END)));
            blank_r       <= (hcount_nxt_s >= HC_W'(H_ACTIVE)) ||
                             (vcount_nxt_s >= VC_W'(V_ACTIVE));
            frame_start_r <= (hcount_nxt_s == '0) && (vcount_nxt_s == '0);
        end
    end

    assign hcount      = hcount_r;
    assign vcount      = vcount_r;
    assign hsync       = hsync_r;
    assign vsync       = vsync_r;
    assign blank       = blank_r;
    assign frame_start = frame_start_r;

endmodule

// File: rtl/infobus_gen.sv
// Information bus generator: buffers tracker samples, commits them once per frame at
// vblank entry, debounces the grab levels and packs everything with the raster timing.
module infobus_gen
    import infobus_pkg::*;
#(
    parameter int GRAB_FRAMES = 2
) (
    input  logic             clockin,
    input  logic             reset_n,
    input  logic             hand_valid,
    input  logic [X_W-1:0]   hand1x,
    input  logic [Y_W-1:0]   hand1y,
    input  logic [X_W-1:0]   hand2x,
    input  logic [Y_W-1:0]   hand2y,
    input  logic             grab1,
    input  logic             grab2,
    output logic [BUS_W-1:0] infoout,
    output logic             frame_start,
    output logic             sample_drop
);

    logic [HC_W-1:0] hcount_s;
    logic [VC_W-1:0] vcount_s;
    logic            hsync_s;
    logic            vsync_s;
    logic            blank_s;
    logic            commit_s;
    hand_sample_t    new_sample_s;
    hand_sample_t    pend_r;
    hand_sample_t    comm_r;
    logic            pend_valid_r;
    logic            sample_drop_r;
    logic [1:0]      raw_grab_s;
    logic [1:0]      grab_out_s;
    logic [BUS_W-1:0] bus_s;

    xvga_timing u_timing (
        .clockin     (clockin),
        .reset_n     (reset_n),
        .hcount      (hcount_s),
        .vcount      (vcount_s),
        .hsync       (hsync_s),
        .vsync       (vsync_s),
        .blank       (blank_s),
        .frame_start (frame_start),
        .commit      (commit_s)
    );

    // Incoming sample with positions clamped to the visible area
    always_comb begin
        new_sample_s.x1 = clamp_x(hand1x);
        new_sample_s.y1 = clamp_y(hand1y);
        new_sample_s.x2 = clamp_x(hand2x);
        new_sample_s.y2 = clamp_y(hand2y);
        new_sample_s.g2 = grab2;
        new_sample_s.g1 = grab1;
    end

    // Raw grab levels that the committed registers will hold after this edge
    always_comb begin
        raw_grab_s = {comm_r.g2, comm_r.g1};
        if (hand_valid) begin
            raw_grab_s = {grab2, grab1};
        end else if (pend_valid_r) begin
            raw_grab_s = {pend_r.g2, pend_r.g1};
        end else begin
            raw_grab_s = {comm_r.g2, comm_r.g1};
        end
    end

    // Pending buffer and once-per-frame commit; a sample in the commit cycle bypasses pending
    always_ff @(posedge clockin or negedge reset_n) begin
        if (!reset_n) begin
            pend_r        <= '0;
            comm_r        <= '0;
            pend_valid_r  <= 1'b0;
            sample_drop_r <= 1'b0;
        end else begin
            sample_drop_r <= 1'b0;
            if (commit_s) begin
                pend_valid_r <= 1'b0;
                if (hand_valid) begin
                    comm_r <= new_sample_s;
                end else if (pend_valid_r) begin
                    comm_r <= pend_r;
                end
            end else if (hand_valid) begin
                pend_r        <= new_sample_s;
                pend_valid_r  <= 1'b1;
                sample_drop_r <= pend_valid_r;
            end
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_grab
        grab_state_t state_r;
        logic [3:0]  cnt_r;
        logic        out_r;

        // Grab debounce: the output flips only after GRAB_FRAMES consecutive differing commits
        always_ff @(posedge clockin or negedge reset_n) begin
            if (!reset_n) begin
                state_r <= GRAB_STABLE;
                cnt_r   <= 4'd0;
                out_r   <= 1'b0;
            end else if (commit_s) begin
                case (state_r)
                    GRAB_STABLE: begin
                        if (raw_grab_s[gi] != out_r) begin
                            if (4'd1 >= 4'(GRAB_FRAMES)) begin
                                out_r <= ~out_r;
                            end else begin
                                cnt_r   <= 4'd1;
                                state_r <= GRAB_CHANGING;
                            end
                        end
                    end
                    GRAB_CHANGING: begin
                        if (raw_grab_s[gi] == out_r) begin
                            state_r <= GRAB_STABLE;
                        end else if ((cnt_r + 4'd1) >= 4'(GRAB_FRAMES)) begin
                            out_r   <= ~out_r;
                            state_r <= GRAB_STABLE;
                        end else begin
                            cnt_r <= cnt_r + 4'd1;
                        end
                    end
                    default: begin
                        state_r <= GRAB_STABLE;
                    end
                endcase
            end
        end

        assign grab_out_s[gi] = out_r;
    end

    // Bus packing from registered sources only
    always_comb begin
        bus_s                   = '0;
        bus_s[ZERO_BIT]         = 1'b0;
        bus_s[HC_MSB:HC_LSB]    = hcount_s;
        bus_s[VC_MSB:VC_LSB]    = vcount_s;
        bus_s[HSYNC_BIT]        = hsync_s;
        bus_s[VSYNC_BIT]        = vsync_s;
        bus_s[BLANK_BIT]        = blank_s;
        bus_s[H1X_MSB:H1X_LSB]  = comm_r.x1;
        bus_s[H1Y_MSB:H1Y_LSB]  = comm_r.y1;
        bus_s[H2X_MSB:H2X_LSB]  = comm_r.x2;
        bus_s[H2Y_MSB:H2Y_LSB]  = comm_r.y2;
        bus_s[GRAB2_BIT]        = grab_out_s[1];
        bus_s[GRAB1_BIT]        = grab_out_s[0];
    end

    assign infoout     = bus_s;
    assign sample_drop = sample_drop_r;

endmodule
